// File: rtl/pixel_enhance_pkg.sv
// Shared definitions for the pixel enhancement pipeline.
// Contents: default sizing, point-operation mode codes, the per-frame
// configuration struct and its reset value.
package pixel_enhance_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned PIX_PER_CLK_DEF = 2;

    // The value field is sized for the default sample width.
    localparam int unsigned CFG_VALUE_W = DATA_W_DEF;
    localparam int unsigned CFG_GAIN_W  = 8;

    localparam logic [2:0] MODE_BYPASS   = 3'd0;
    localparam logic [2:0] MODE_ADD      = 3'd1;
    localparam logic [2:0] MODE_SUB      = 3'd2;
    localparam logic [2:0] MODE_CONTRAST = 3'd3;
    localparam logic [2:0] MODE_THRESH   = 3'd4;
    localparam logic [2:0] MODE_INVERT   = 3'd5;

    typedef struct packed {
        logic [2:0]             mode;
        logic [CFG_VALUE_W-1:0] value;
        logic [CFG_GAIN_W-1:0]  gain;
    } pix_cfg_t;

    // Bypass, zero offset, unity gain.
    localparam pix_cfg_t CFG_RESET = '{mode: MODE_BYPASS, value: '0, gain: 8'h10};

endpackage

// File: rtl/pixel_lane_op.sv
// Per-lane point operation, fully combinational.
// Ports:
//   pix    : input sample for the stage-1 operation
//   cfg    : configuration applied to pix
//   ext_c  : extended (unclamped) result, two's complement, to stage-1 register
//   ext_in : extended result held in stage 1, to be clamped
//   res_c  : clamped sample for stage 2
//   clip_c : ext_in was outside [0, MAX]
module pixel_lane_op
    import pixel_enhance_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned GAIN_FRAC = 4,
    localparam int unsigned EXT_W    = DATA_W + 9
) (
    input  logic [DATA_W-1:0] pix,
    input  pix_cfg_t          cfg,
    output logic [EXT_W-1:0]  ext_c,
    input  logic [EXT_W-1:0]  ext_in,
    output logic [DATA_W-1:0] res_c,
    output logic              clip_c
);

    localparam logic [EXT_W-1:0] MAX_EXT = (EXT_W'(1) << DATA_W) - EXT_W'(1);

    logic [DATA_W-1:0] val;
    logic [EXT_W-1:0]  pix_ext;
    logic [EXT_W-1:0]  val_ext;
    logic [EXT_W-1:0]  gain_ext;

    // Operation on the extended range; only sub can go negative (MSB set).
    always_comb begin
        val      = DATA_W'(cfg.value);
        pix_ext  = EXT_W'(pix);
        val_ext  = EXT_W'(val);
        gain_ext = EXT_W'(cfg.gain);
        ext_c    = pix_ext;
        case (cfg.mode)
            MODE_ADD:      ext_c = pix_ext + val_ext;
            MODE_SUB:      ext_c = pix_ext - val_ext;
            MODE_CONTRAST: ext_c = (pix_ext * gain_ext) >> GAIN_FRAC;
            MODE_THRESH:   ext_c = (pix >= val) ? MAX_EXT : '0;
            MODE_INVERT:   ext_c = MAX_EXT - pix_ext;
            default:       ext_c = pix_ext;
        endcase
    end

    // Clamp to [0, MAX]; bypass/threshold/invert stay in range so never flag.
    always_comb begin
        res_c  = ext_in[DATA_W-1:0];
        clip_c = 1'b0;
        if (ext_in[EXT_W-1]) begin
            res_c  = '0;
            clip_c = 1'b1;
        end else if (ext_in > MAX_EXT) begin
            res_c  = '1;
            clip_c = 1'b1;
        end
    end

endmodule

// File: rtl/pixel_enhance_pipe.sv
// Streaming pixel enhancement: two-stage valid/ready pipeline applying a
// per-frame latched point operation to every channel lane, with per-frame
// clip statistics.
// Ports:
//   HCLK, HRESETn             : clock, asynchronous reset (asserted high)
//   cfg_mode/value/gain       : operation settings, sampled at frame start
//   in_valid/ready/data/hsync/vsync    : input beat stream
//   out_valid/ready/data/hsync/vsync   : output beat stream
//   sat_count                 : clipped beats of the last completed frame
//   frame_done                : one-cycle pulse after each frame end
module pixel_enhance_pipe
    import pixel_enhance_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned PIX_PER_CLK = PIX_PER_CLK_DEF,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned GAIN_FRAC   = 4,
    localparam int unsigned LANES      = PIX_PER_CLK * CHANNELS,
    localparam int unsigned BUS_W      = LANES * DATA_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [2:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [7:0]        cfg_gain,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BUS_W-1:0]  in_data,
    input  logic              in_hsync,
    input  logic              in_vsync,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUS_W-1:0]  out_data,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [15:0]       sat_count,
    output logic              frame_done
);

    localparam int unsigned EXT_W = DATA_W + 9;

    // Stage 1: extended lane results
    logic             s1_valid_q, s1_valid_d;
    logic [EXT_W-1:0] s1_ext_q [LANES];
    logic [EXT_W-1:0] s1_ext_d [LANES];
    logic             s1_hsync_q, s1_hsync_d;
    logic             s1_vsync_q, s1_vsync_d;

    // Stage 2: clamped output beat
    logic             out_valid_q, out_valid_d;
    logic [BUS_W-1:0] out_data_q, out_data_d;
    logic             out_clip_q, out_clip_d;
    logic             out_hsync_q, out_hsync_d;
    logic             out_vsync_q, out_vsync_d;

    // Config latch and statistics
    pix_cfg_t         cfg_act_q, cfg_act_d;
    logic             in_vsync_prev_q, in_vsync_prev_d;
    logic             out_vsync_prev_q, out_vsync_prev_d;
    logic [15:0]      run_cnt_q, run_cnt_d;
    logic [15:0]      sat_count_q, sat_count_d;
    logic             frame_done_q, frame_done_d;

    // Combinational control
    logic             adv_c;
    logic             in_acc_c;
    logic             out_acc_c;
    logic             frame_start_c;
    logic             frame_end_c;
    pix_cfg_t         cfg_new_c;
    pix_cfg_t         cfg_use_c;

    logic [EXT_W-1:0]  lane_ext_c [LANES];
    logic [DATA_W-1:0] lane_res_c [LANES];
    logic [LANES-1:0]  lane_clip_c;
    logic [BUS_W-1:0]  res_bus_c;
    logic              clip_any_c;

    // Handshake, frame boundaries and the config seen by the incoming beat.
    always_comb begin
        adv_c         = !out_valid_q || out_ready;
        in_acc_c      = in_valid && adv_c;
        out_acc_c     = out_valid_q && out_ready;
        frame_start_c = in_acc_c && in_vsync && !in_vsync_prev_q;
        frame_end_c   = out_acc_c && !out_vsync_q && out_vsync_prev_q;
        cfg_new_c.mode  = cfg_mode;
        cfg_new_c.value = CFG_VALUE_W'(cfg_value);
        cfg_new_c.gain  = cfg_gain;
        // The first beat of a frame already uses the freshly sampled settings.
        cfg_use_c = frame_start_c ? cfg_new_c : cfg_act_q;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pixel_lane_op #(
            .DATA_W    (DATA_W),
            .GAIN_FRAC (GAIN_FRAC)
        ) u_lane (
            .pix    (in_data[k*DATA_W +: DATA_W]),
            .cfg    (cfg_use_c),
            .ext_c  (lane_ext_c[k]),
            .ext_in (s1_ext_q[k]),
            .res_c  (lane_res_c[k]),
            .clip_c (lane_clip_c[k])
        );
    end

    // Lane result packing and beat-level clip flag.
    always_comb begin
        res_bus_c  = '0;
        clip_any_c = |lane_clip_c;
        for (int unsigned k = 0; k < LANES; k++) begin
            res_bus_c[k*DATA_W +: DATA_W] = lane_res_c[k];
        end
    end

    // Next-state: pipeline advance, config latch, statistics.
    always_comb begin
        s1_valid_d       = s1_valid_q;
        s1_ext_d         = s1_ext_q;
        s1_hsync_d       = s1_hsync_q;
        s1_vsync_d       = s1_vsync_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_clip_d       = out_clip_q;
        out_hsync_d      = out_hsync_q;
        out_vsync_d      = out_vsync_q;
        cfg_act_d        = cfg_act_q;
        in_vsync_prev_d  = in_vsync_prev_q;
        out_vsync_prev_d = out_vsync_prev_q;
        run_cnt_d        = run_cnt_q;
        sat_count_d      = sat_count_q;
        frame_done_d     = frame_end_c;

        // Both stages move together; bubbles travel as invalid beats.
        if (adv_c) begin
            s1_valid_d  = in_valid;
            s1_ext_d    = lane_ext_c;
            s1_hsync_d  = in_hsync;
            s1_vsync_d  = in_vsync;
            out_valid_d = s1_valid_q;
            out_data_d  = res_bus_c;
            out_clip_d  = s1_valid_q && clip_any_c;
            out_hsync_d = s1_hsync_q;
            out_vsync_d = s1_vsync_q;
        end

        if (in_acc_c) begin
            in_vsync_prev_d = in_vsync;
        end
        if (frame_start_c) begin
            cfg_act_d = cfg_new_c;
        end

        if (out_acc_c) begin
            out_vsync_prev_d = out_vsync_q;
            if (out_clip_q && out_vsync_q && (run_cnt_q != 16'hFFFF)) begin
                run_cnt_d = run_cnt_q + 16'd1;
            end
        end
        // The frame-end beat has vsync low, so it never adds to the count.
        if (frame_end_c) begin
            sat_count_d = run_cnt_q;
            run_cnt_d   = '0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            s1_valid_q       <= 1'b0;
            s1_ext_q         <= '{default: '0};
            s1_hsync_q       <= 1'b0;
            s1_vsync_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_clip_q       <= 1'b0;
            out_hsync_q      <= 1'b0;
            out_vsync_q      <= 1'b0;
            cfg_act_q        <= CFG_RESET;
            in_vsync_prev_q  <= 1'b0;
            out_vsync_prev_q <= 1'b0;
            run_cnt_q        <= '0;
            sat_count_q      <= '0;
            frame_done_q     <= 1'b0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_ext_q         <= s1_ext_d;
            s1_hsync_q       <= s1_hsync_d;
            s1_vsync_q       <= s1_vsync_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_clip_q       <= out_clip_d;
            out_hsync_q      <= out_hsync_d;
            out_vsync_q      <= out_vsync_d;
            cfg_act_q        <= cfg_act_d;
            in_vsync_prev_q  <= in_vsync_prev_d;
            out_vsync_prev_q <= out_vsync_prev_d;
            run_cnt_q        <= run_cnt_d;
            sat_count_q      <= sat_count_d;
            frame_done_q     <= frame_done_d;
        end
    end

    assign in_ready   = adv_c;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_hsync  = out_hsync_q;
    assign out_vsync  = out_vsync_q;
    assign sat_count  = sat_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_enhance_pipe.sv
// Self-checking bench for pixel_enhance_pipe: directed and random beats
// against a per-beat arithmetic reference model and frame statistics model.
module tb_pixel_enhance_pipe;

    localparam int DW   = 8;
    localparam int LN   = 6;
    localparam int BW   = LN * DW;
    localparam int GF   = 4;
    localparam int MAXV = 255;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [2:0]    cfg_mode;
    logic [DW-1:0] cfg_value;
    logic [7:0]    cfg_gain;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_hsync;
    logic          in_vsync;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_hsync;
    logic          out_vsync;
    logic [15:0]   sat_count;
    logic          frame_done;

    pixel_enhance_pipe #(
        .DATA_W      (DW),
        .PIX_PER_CLK (2),
        .CHANNELS    (3),
        .GAIN_FRAC   (GF)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cfg_mode   (cfg_mode),
        .cfg_value  (cfg_value),
        .cfg_gain   (cfg_gain),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .sat_count  (sat_count),
        .frame_done (frame_done)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [BW-1:0] data;
        logic          hs;
        logic          vs;
        logic          clip;
        int            t_in;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;
    int fd_seen = 0;
    int m_frames = 0;

    // Reference model state
    int   m_mode, m_val, m_gain;
    logic m_in_pvs, m_out_pvs;
    int   m_run;
    logic [15:0] m_sat;
    logic exp_fd;

    logic lat_mode = 1'b0;
    logic rdy_rand = 1'b0;
    logic last_in_acc = 1'b0;
    logic stall_prev = 1'b0;
    logic [BW-1:0] hold_data;
    logic [1:0]    hold_sync;
    logic [BW-1:0] last_out = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rep(input logic [7:0] b);
        logic [BW-1:0] r;
        for (int k = 0; k < LN; k++) r[k*DW +: DW] = b;
        return r;
    endfunction

    // Each lane: plain integer arithmetic, then clip to the sample range.
    task automatic ref_beat(input logic [BW-1:0] d, output logic [BW-1:0] o, output logic clip);
        clip = 1'b0;
        o    = '0;
        for (int k = 0; k < LN; k++) begin
            int p;
            int r;
            p = int'(d[k*DW +: DW]);
            case (m_mode)
                1:       r = p + m_val;
                2:       r = p - m_val;
                3:       r = (p * m_gain) / (1 << GF);
                4:       r = (p >= m_val) ? MAXV : 0;
                5:       r = MAXV - p;
                default: r = p;
            endcase
            if (r > MAXV) begin r = MAXV; clip = 1'b1; end
            if (r < 0)    begin r = 0;    clip = 1'b1; end
            o[k*DW +: DW] = DW'(r);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_gain = 16;
        m_in_pvs = 1'b0; m_out_pvs = 1'b0;
        m_run = 0; m_sat = '0; exp_fd = 1'b0;
        stall_prev = 1'b0;
        q.delete();
    endtask

    // One clock: check at negedge, update model from handshakes, move past posedge.
    task automatic cyc();
        logic ia;
        logic oa;
        exp_t e;
        @(negedge HCLK);
        cyc_no++;
        if (lat_mode) chk("in_ready_full", 64'(in_ready), 64'(1'b1));
        chk("frame_done", 64'(frame_done), 64'(exp_fd));
        chk("sat_count", 64'(sat_count), 64'(m_sat));
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'(1'b1));
            chk("stall_data", 64'(out_data), 64'(hold_data));
            chk("stall_sync", 64'({out_hsync, out_vsync}), 64'(hold_sync));
        end
        if (frame_done === 1'b1) fd_seen++;
        ia = in_valid && in_ready;
        oa = out_valid && out_ready;
        exp_fd = 1'b0;
        if (oa) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 64'(out_valid), 64'(1'b0));
            end else begin
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_sync", 64'({out_hsync, out_vsync}), 64'({e.hs, e.vs}));
                if (lat_mode) chk("latency", 64'(cyc_no - e.t_in), 64'(2));
                last_out = out_data;
                if (e.clip && e.vs && m_run < 65535) m_run++;
                if (!e.vs && m_out_pvs) begin
                    m_sat = 16'(m_run);
                    m_run = 0;
                    exp_fd = 1'b1;
                    m_frames++;
                end
                m_out_pvs = e.vs;
            end
        end
        stall_prev = out_valid && !out_ready;
        hold_data  = out_data;
        hold_sync  = {out_hsync, out_vsync};
        if (ia) begin
            if (in_vsync && !m_in_pvs) begin
                m_mode = int'(cfg_mode);
                m_val  = int'(cfg_value);
                m_gain = int'(cfg_gain);
            end
            m_in_pvs = in_vsync;
            ref_beat(in_data, e.data, e.clip);
            e.hs   = in_hsync;
            e.vs   = in_vsync;
            e.t_in = cyc_no;
            q.push_back(e);
        end
        last_in_acc = ia;
        @(posedge HCLK);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send(input logic [BW-1:0] d, input logic hs, input logic vs);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_hsync = hs;
        in_vsync = vs;
        do begin
            cyc();
            n++;
        end while (!last_in_acc && n < 200);
        if (!last_in_acc) chk("send_timeout", 64'(in_ready), 64'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < limit) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'(0));
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        HRESETn   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge HCLK);
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_sat", 64'(sat_count), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(1'b0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sync", 64'({out_hsync, out_vsync}), 64'(0));
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        model_reset();
    endtask

    task automatic set_cfg(input logic [2:0] m, input logic [7:0] v, input logic [7:0] g);
        cfg_mode  = m;
        cfg_value = v;
        cfg_gain  = g;
    endtask

    initial begin
        HRESETn  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        out_ready = 1'b1;
        set_cfg(3'd0, 8'h00, 8'h10);
        model_reset();

        // T1: add with saturation, latency 2, sat_count of a frame
        do_reset();
        lat_mode = 1'b1;
        set_cfg(3'd1, 8'h40, 8'h10);
        repeat (4) send(48'hF010_F010_F010, 1'b1, 1'b1);
        send(48'hF010_F010_F010, 1'b0, 1'b0);
        drain(50);
        chk("t1_last_beat", 64'(last_out), 64'(48'hFF50_FF50_FF50));
        chk("t1_sat", 64'(sat_count), 64'(16'd4));

        // T2: contrast x1.5, contrast clip, subtract floor
        set_cfg(3'd3, 8'h00, 8'h18);
        send(rep(8'h80), 1'b1, 1'b1);
        drain(50);
        chk("t2_gain", 64'(last_out), 64'(rep(8'hC0)));
        send(rep(8'hB0), 1'b1, 1'b1);
        drain(50);
        chk("t2_gain_clip", 64'(last_out), 64'(rep(8'hFF)));
        send(rep(8'h00), 1'b0, 1'b0);
        drain(50);
        chk("t2_sat", 64'(sat_count), 64'(16'd1));
        set_cfg(3'd2, 8'h20, 8'h10);
        send(rep(8'h10), 1'b1, 1'b1);
        drain(50);
        chk("t2_sub", 64'(last_out), 64'(rep(8'h00)));
        send(rep(8'h50), 1'b0, 1'b0);
        drain(50);
        chk("t2_sub_sat", 64'(sat_count), 64'(16'd1));

        // T3: mid-frame config change waits for the next frame
        set_cfg(3'd1, 8'h10, 8'h10);
        send(rep(8'h20), 1'b1, 1'b1);
        send(rep(8'h20), 1'b1, 1'b1);
        set_cfg(3'd5, 8'h10, 8'h10);
        send(rep(8'h20), 1'b1, 1'b1);
        send(rep(8'h20), 1'b1, 1'b1);
        drain(50);
        chk("t3_still_add", 64'(last_out), 64'(rep(8'h30)));
        send(rep(8'h20), 1'b0, 1'b0);
        send(rep(8'h0F), 1'b1, 1'b1);
        drain(50);
        chk("t3_invert", 64'(last_out), 64'(rep(8'hF0)));
        send(rep(8'h0F), 1'b0, 1'b0);
        drain(50);

        // T4: random frames, random gaps, random backpressure
        lat_mode = 1'b0;
        rdy_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int nb;
            set_cfg(3'($urandom_range(0, 7)), 8'($urandom()), 8'($urandom()));
            nb = $urandom_range(3, 12);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) cyc();
                end
                if (b == 2) set_cfg(3'($urandom_range(0, 7)), 8'($urandom()), 8'($urandom()));
                send(48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)), 1'b1);
            end
            repeat ($urandom_range(1, 2)) send(48'({$urandom(), $urandom()}), 1'b0, 1'b0);
        end
        drain(2000);
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        cyc();

        // T5: reset mid-frame drops in-flight beats and reverts to bypass
        lat_mode = 1'b1;
        set_cfg(3'd1, 8'h30, 8'h10);
        send(rep(8'h11), 1'b1, 1'b1);
        send(rep(8'h11), 1'b1, 1'b1);
        send(rep(8'h11), 1'b1, 1'b1);
        do_reset();
        send(rep(8'h11), 1'b0, 1'b0);
        send(rep(8'h11), 1'b0, 1'b0);
        drain(50);
        chk("t5_bypass", 64'(last_out), 64'(rep(8'h11)));

        // T6: counter saturation over a very long clipping frame
        set_cfg(3'd1, 8'hFF, 8'h10);
        for (int b = 0; b < 70000; b++) send(rep(8'h80), 1'b1, 1'b1);
        send(rep(8'h80), 1'b0, 1'b0);
        drain(50);
        chk("t6_sat_max", 64'(sat_count), 64'(16'hFFFF));

        chk("frame_done_total", 64'(fd_seen), 64'(m_frames));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
